// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Frame-buffer read side of the display path. A clock-enable divider
//   produces the pixel strobe. Free-running h/v counters generate VGA timing
//   and read the stored image row-major from a synchronous RAM. A two-stage
//   pipeline presents the pixel value, sync and blanking. All presented
//   outputs change together, two clks after the strobe for that pixel.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active low
//   rd_data      in   RAM read data, valid 1 clk after rd_en
//   rd_en        out  one-clk read request (coincides with pix_ce)
//   rd_addr      out  read address, valid while rd_en=1
//   pix_ce       out  one-clk pixel strobe, once every DIV clks
//   hsync        out  horizontal sync, SYNC_POL active
//   vsync        out  vertical sync, SYNC_POL active
//   video_on     out  1 inside the active area
//   pixel_x      out  horizontal position of the presented pixel
//   pixel_y      out  vertical position of the presented pixel
//   pixel_out    out  pixel value, 0 outside the image window
//   frame_start  out  one-clk pulse when pixel (0,0) is presented

module vga_frame_reader #(
  parameter int unsigned DIV      = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned CNT_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_ce,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [CNT_W-1:0]  pixel_x,
  output logic [CNT_W-1:0]  pixel_y,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  localparam int unsigned DIV_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic        SYNC_ACT = 1'(SYNC_POL != 0);

  // Configuration sanity check
  if (DIV < 2 || IMG_W > H_ACTIVE || IMG_H > V_ACTIVE) begin : g_cfg_check
    $error("vga_frame_reader: invalid configuration (DIV<2 or image larger than active area)");
  end

  // Divider, timing counters and read address
  logic [DIV_W-1:0]  r_div;
  logic              r_pix_ce;
  logic [CNT_W-1:0]  r_h;
  logic [CNT_W-1:0]  r_v;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;

  // Stage 1: decode of the strobed (h,v)
  logic              r_s1_vld;
  logic              r_s1_von;
  logic              r_s1_hs;
  logic              r_s1_vs;
  logic              r_s1_img;
  logic              r_s1_frame;
  logic [CNT_W-1:0]  r_s1_x;
  logic [CNT_W-1:0]  r_s1_y;

  // Stage 2: presented outputs
  logic              r_hsync;
  logic              r_vsync;
  logic              r_video_on;
  logic [CNT_W-1:0]  r_pixel_x;
  logic [CNT_W-1:0]  r_pixel_y;
  logic [PIX_W-1:0]  r_pixel_out;
  logic              r_frame_start;

  logic w_div_last;
  logic w_h_last;
  logic w_v_last;
  logic w_video_on;
  logic w_in_img;
  logic w_hs_act;
  logic w_vs_act;
  logic w_frame0;

  // Decode of the current counter position
  assign w_div_last = (r_div == DIV_W'(DIV - 1));
  assign w_h_last   = (r_h == CNT_W'(H_TOTAL - 1));
  assign w_v_last   = (r_v == CNT_W'(V_TOTAL - 1));
  assign w_video_on = (r_h < CNT_W'(H_ACTIVE)) && (r_v < CNT_W'(V_ACTIVE));
  assign w_in_img   = (r_h < CNT_W'(IMG_W)) && (r_v < CNT_W'(IMG_H));
  assign w_hs_act   = (r_h >= CNT_W'(HS_BEG)) && (r_h < CNT_W'(HS_END));
  assign w_vs_act   = (r_v >= CNT_W'(VS_BEG)) && (r_v < CNT_W'(VS_END));
  assign w_frame0   = (r_h == '0) && (r_v == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_pix_ce      <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_addr        <= '0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_s1_vld      <= 1'b0;
      r_s1_von      <= 1'b0;
      r_s1_hs       <= ~SYNC_ACT;
      r_s1_vs       <= ~SYNC_ACT;
      r_s1_img      <= 1'b0;
      r_s1_frame    <= 1'b0;
      r_s1_x        <= '0;
      r_s1_y        <= '0;
      r_hsync       <= ~SYNC_ACT;
      r_vsync       <= ~SYNC_ACT;
      r_video_on    <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_pixel_out   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      // The strobe is registered off the last divider count, so it is high
      // while the divider sits at 0 and the first one lands DIV clks after reset.
      r_div    <= w_div_last ? '0 : r_div + DIV_W'(1);
      r_pix_ce <= w_div_last;

      // Read request is launched alongside the strobe; h/v are stable on
      // this edge because they only move on strobe edges.
      r_rd_en <= w_div_last && w_in_img;
      if (w_div_last && w_in_img) begin
        r_rd_addr <= r_addr;
        r_addr    <= r_addr + ADDR_W'(1);
      end

      r_s1_vld <= r_pix_ce;
      if (r_pix_ce) begin
        r_s1_von   <= w_video_on;
        r_s1_hs    <= w_hs_act ? SYNC_ACT : ~SYNC_ACT;
        r_s1_vs    <= w_vs_act ? SYNC_ACT : ~SYNC_ACT;
        r_s1_img   <= w_in_img;
        r_s1_frame <= w_frame0;
        r_s1_x     <= r_h;
        r_s1_y     <= r_v;

        // Raster advance; the image is never in view at the frame wrap,
        // so the address clear cannot collide with an increment.
        if (w_h_last) begin
          r_h <= '0;
          if (w_v_last) begin
            r_v    <= '0;
            r_addr <= '0;
          end else begin
            r_v <= r_v + CNT_W'(1);
          end
        end else begin
          r_h <= r_h + CNT_W'(1);
        end
      end

      // Stage 2 coincides with RAM data for the read launched with the strobe
      if (r_s1_vld) begin
        r_hsync     <= r_s1_hs;
        r_vsync     <= r_s1_vs;
        r_video_on  <= r_s1_von;
        r_pixel_x   <= r_s1_x;
        r_pixel_y   <= r_s1_y;
        r_pixel_out <= r_s1_img ? rd_data : '0;
      end
      r_frame_start <= r_s1_vld && r_s1_frame;
    end
  end

  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;
  assign pix_ce      = r_pix_ce;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign pixel_out   = r_pixel_out;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader
//   Two instances: A with the default 640x480 timing and a 256x256 image,
//   B with DIV=4 and a tiny 8x4 raster holding a 4x2 image. Directed vectors
//   with hand-computed expectations plus negedge monitors for periodic timing.

module tb_vga_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  // Instance A signals
  logic [7:0]  a_rd_data = '0;
  logic        a_rd_en;
  logic [15:0] a_rd_addr;
  logic        a_pix_ce, a_hs, a_vs, a_von, a_fs;
  logic [9:0]  a_x, a_y;
  logic [7:0]  a_pix;

  // Instance B signals
  logic [7:0]  b_rd_data = '0;
  logic        b_rd_en;
  logic [2:0]  b_rd_addr;
  logic        b_pix_ce, b_hs, b_vs, b_von, b_fs;
  logic [9:0]  b_x, b_y;
  logic [7:0]  b_pix;

  vga_frame_reader u_a (
    .clk(clk), .rst_n(rst_a), .rd_data(a_rd_data), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .pix_ce(a_pix_ce), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
    .pixel_x(a_x), .pixel_y(a_y), .pixel_out(a_pix), .frame_start(a_fs)
  );

  vga_frame_reader #(
    .DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .IMG_W(4), .IMG_H(2), .ADDR_W(3)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .rd_data(b_rd_data), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .pix_ce(b_pix_ce), .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
    .pixel_x(b_x), .pixel_y(b_y), .pixel_out(b_pix), .frame_start(b_fs)
  );

  // Synchronous RAM models
  always @(posedge clk) if (a_rd_en) a_rd_data <= a_rd_addr[15:8] ^ a_rd_addr[7:0];
  always @(posedge clk) if (b_rd_en) b_rd_data <= {5'b10100, b_rd_addr};

  int n_tests = 0;
  int n_fail  = 0;
  int t_edge  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t_edge++;
  endtask

  // First edges of A after a reset release (k = edges since release)
  task automatic check_a_start(input int k);
    chk("a_pix_ce", 64'(a_pix_ce), 64'(k % 2 == 0));
    chk("a_rd_en", 64'(a_rd_en), 64'(k % 2 == 0));
    if (k % 2 == 0) chk("a_rd_addr", 64'(a_rd_addr), 64'(k / 2 - 1));
    chk("a_frame_start", 64'(a_fs), 64'(k == 4));
    chk("a_pixel_out_start", 64'(a_pix), (k < 6) ? 64'd0 : 64'((k - 4) / 2));
    if (k == 4) chk("a_xy_origin", 64'({a_x, a_y}), 64'd0);
  endtask

  // Instance A monitor: line timing, counted in clks
  logic a_mon = 1'b0;
  int   an = 0, a_hs_fall = 0, a_hs_low = 0, a_hs_per = 0;
  int   a_von_rise = 0, a_von_len = 0, a_rd_win = 0, a_line_reads = 0;
  logic a_hs_prev = 1'b1, a_von_prev = 1'b0;

  always @(negedge clk) if (a_mon) begin
    an++;
    if (a_hs_prev && !a_hs) begin
      if (a_hs_fall > 0) begin
        a_hs_per     = an - a_hs_fall;
        a_line_reads = a_rd_win;
      end
      a_hs_fall = an;
      a_rd_win  = 0;
    end
    if (!a_hs_prev && a_hs && a_hs_fall > 0) a_hs_low = an - a_hs_fall;
    if (a_rd_en) a_rd_win++;
    if (!a_von_prev && a_von) a_von_rise = an;
    if (a_von_prev && !a_von && a_von_rise > 0) a_von_len = an - a_von_rise;
    a_hs_prev  = a_hs;
    a_von_prev = a_von;
  end

  // Instance B monitor: output timing, read sequence, frame and sync timing
  logic        b_mon = 1'b0;
  int          bn = 0, b_rd_total = 0, b_rd_win = 0, b_addr0_n = 0, b_frames = 0;
  int          b_hs_fall = 0, b_hs_low = 0, b_hs_per = 0;
  int          b_vs_fall = 0, b_vs_low = 0, b_vs_per = 0;
  int          b_von_rise = 0, b_von_len = 0;
  logic        b_hs_prev = 1'b1, b_vs_prev = 1'b1, b_von_prev = 1'b0, b_fs_prev = 1'b0;
  logic        b_pce_d1 = 1'b0, b_pce_d2 = 1'b0;
  logic [30:0] b_prev_out = '0;

  always @(negedge clk) if (b_mon && bn < 2000) begin
    bn++;
    if (bn > 1)
      chk("b_out_timing", 64'({b_x, b_y, b_von, b_hs, b_vs, b_pix} != b_prev_out), 64'(b_pce_d2));
    b_prev_out = {b_x, b_y, b_von, b_hs, b_vs, b_pix};
    b_pce_d2   = b_pce_d1;
    b_pce_d1   = b_pix_ce;

    if (b_rd_en) begin
      chk("b_rd_addr", 64'(b_rd_addr), 64'(b_rd_total % 8));
      if (b_rd_addr == 3'd0) b_addr0_n = bn;
      b_rd_total++;
      b_rd_win++;
    end
    if (b_fs) begin
      chk("b_fs_width", 64'(b_fs_prev), 64'd0);
      chk("b_fs_after_addr0", 64'(bn - b_addr0_n), 64'd2);
      if (b_frames > 0) chk("b_reads_per_frame", 64'(b_rd_win), 64'd8);
      b_frames++;
      b_rd_win = 0;
    end

    if (b_hs_prev && !b_hs) begin
      if (b_hs_fall > 0) b_hs_per = bn - b_hs_fall;
      b_hs_fall = bn;
    end
    if (!b_hs_prev && b_hs && b_hs_fall > 0) b_hs_low = bn - b_hs_fall;
    if (b_vs_prev && !b_vs) begin
      if (b_vs_fall > 0) b_vs_per = bn - b_vs_fall;
      b_vs_fall = bn;
    end
    if (!b_vs_prev && b_vs && b_vs_fall > 0) b_vs_low = bn - b_vs_fall;
    if (!b_von_prev && b_von) b_von_rise = bn;
    if (b_von_prev && !b_von && b_von_rise > 0) b_von_len = bn - b_von_rise;
    b_hs_prev  = b_hs;
    b_vs_prev  = b_vs;
    b_von_prev = b_von;
    b_fs_prev  = b_fs;
  end

  // Instance A vectors: pixel (x,y), expected presented outputs
  typedef struct {
    int unsigned x;
    int unsigned y;
    logic        von;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [7:0]  pix;
  } vec_t;

  localparam int N_VEC = 14;
  vec_t tbl [N_VEC];

  initial begin
    tbl[0]  = '{5,   0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h05};
    tbl[1]  = '{255, 0,  1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[2]  = '{256, 0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{639, 0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{640, 0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{656, 0,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{751, 0,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{752, 0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{799, 0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{0,   1,  1'b1, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[10] = '{255, 1,  1'b1, 1'b1, 1'b1, 1'b0, 8'hFE};
    tbl[11] = '{5,   2,  1'b1, 1'b1, 1'b1, 1'b0, 8'h07};
    tbl[12] = '{100, 3,  1'b1, 1'b1, 1'b1, 1'b0, 8'h67};
    tbl[13] = '{300, 10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    // Reset held for 10 clks
    repeat (10) tick();
    chk("a_rst_sync", 64'({a_hs, a_vs}), 64'b11);
    chk("a_rst_ctrl", 64'({a_rd_en, a_pix_ce, a_von, a_fs}), 64'd0);
    chk("a_rst_addr", 64'(a_rd_addr), 64'd0);
    chk("a_rst_pix", 64'(a_pix), 64'd0);
    chk("a_rst_xy", 64'({a_x, a_y}), 64'd0);
    chk("b_rst_sync", 64'({b_hs, b_vs}), 64'b11);

    rst_a  = 1'b1;
    rst_b  = 1'b1;
    t_edge = 0;
    a_mon  = 1'b1;
    b_mon  = 1'b1;

    // First edges after release for both instances
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_a_start(k);
      chk("b_pix_ce", 64'(b_pix_ce), 64'(k % 4 == 0));
      chk("b_rd_en", 64'(b_rd_en), 64'(k % 4 == 0));
      chk("b_frame_start", 64'(b_fs), 64'(k == 6));
      chk("b_video_on", 64'(b_von), 64'(k >= 6));
      chk("b_pixel_out", 64'(b_pix), (k >= 6) ? 64'hA0 : 64'd0);
    end

    // Pixel n = y*800+x is presented from edge 2n+4 after release
    for (int i = 0; i < N_VEC; i++) begin
      int target;
      target = 2 * int'(tbl[i].y * 800 + tbl[i].x) + 4;
      while (t_edge < target) tick();
      chk($sformatf("vec%0d", i),
          64'({a_x, a_y, a_von, a_hs, a_vs, a_fs, a_pix}),
          64'({10'(tbl[i].x), 10'(tbl[i].y), tbl[i].von, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].pix}));
    end

    chk("a_hsync_low_clks", 64'(a_hs_low), 64'd192);
    chk("a_hsync_period", 64'(a_hs_per), 64'd1600);
    chk("a_video_on_clks", 64'(a_von_len), 64'd1280);
    chk("a_reads_per_line", 64'(a_line_reads), 64'd256);
    chk("b_hsync_low_clks", 64'(b_hs_low), 64'd8);
    chk("b_hsync_period", 64'(b_hs_per), 64'd56);
    chk("b_vsync_low_clks", 64'(b_vs_low), 64'd56);
    chk("b_vsync_period", 64'(b_vs_per), 64'd392);
    chk("b_video_on_clks", 64'(b_von_len), 64'd32);
    chk("b_frames_seen", 64'(b_frames >= 3), 64'd1);

    // Asynchronous reset mid-line, between clock edges
    a_mon = 1'b0;
    #2;
    rst_a = 1'b0;
    #1;
    chk("a_midrst_sync", 64'({a_hs, a_vs}), 64'b11);
    chk("a_midrst_ctrl", 64'({a_rd_en, a_pix_ce, a_von, a_fs}), 64'd0);
    chk("a_midrst_addr", 64'(a_rd_addr), 64'd0);
    chk("a_midrst_pix", 64'(a_pix), 64'd0);
    chk("a_midrst_xy", 64'({a_x, a_y}), 64'd0);
    repeat (3) tick();
    rst_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_a_start(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
